shake_coeff_sampler: RTL and testbench

//   Rejection sampler downstream of shake256. Consumes the 64-bit squeeze stream
//   (data_out/keep/valid/ready/last) and splits each word into four 16-bit LE

---
 rtl/shake_coeff_sampler.sv | 170 +++++++++++++++++
 tb/tb_shake_coeff_sampler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shake_coeff_sampler.sv
`default_nettype none
// ============================================================================
// Module   : shake_coeff_sampler
// Brief    : Rejection sampler on the shake256 squeeze stream. Emits N
//            coefficients in [0, Q-1] from 16-bit little-endian candidates.
// Revision : 1.0 - initial release
// ============================================================================
module shake_coeff_sampler #(
    parameter int Q       = 12289,
    parameter int COEFF_W = 14,
    parameter int N       = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [63:0]              in_data,
    input  logic [7:0]               in_keep,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    output logic [COEFF_W-1:0]       coeff,
    output logic                     coeff_valid,
    input  logic                     coeff_ready,
    output logic                     coeff_last,
    output logic [$clog2(N+1)-1:0]   coeff_cnt,
    output logic                     done,
    output logic                     error
);

    localparam int               CNT_W      = $clog2(N + 1);
    localparam logic [16:0]      c_Q        = 17'(Q);
    localparam logic [16:0]      c_MASK     = 17'((1 << COEFF_W) - 1);
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SCAN  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [63:0]      r_buf_data;
    logic [7:0]       r_buf_keep;
    logic             r_buf_last;
    logic [1:0]       r_lane;
    logic [CNT_W-1:0] r_cnt;
    logic             r_error;

    logic [16:0]      w_cand;
    logic             w_usable;
    logic             w_run_start;
    logic             w_load;
    logic             w_take;
    logic             w_advance;
    logic             w_set_error;

    // Extra zero MSB lets the Q compare work even when Q == 2^COEFF_W.
    assign w_cand   = {1'b0, r_buf_data[{r_lane, 4'b0000} +: 16]} & c_MASK;
    assign w_usable = &r_buf_keep[{r_lane, 1'b0} +: 2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        coeff_valid = 1'b0;
        coeff_last  = 1'b0;
        done        = 1'b0;
        w_run_start = 1'b0;
        w_load      = 1'b0;
        w_take      = 1'b0;
        w_advance   = 1'b0;
        w_set_error = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_run_start = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_usable && (w_cand < c_Q)) begin
                    coeff_valid = 1'b1;
                    coeff_last  = (r_cnt == c_LAST_CNT);
                    if (coeff_ready) begin
                        w_take = 1'b1;
                        if (coeff_last) begin
                            w_state_nxt = r_buf_last ? S_DONE : S_DRAIN;
                        end else begin
                            w_advance = 1'b1;
                        end
                    end
                end else begin
                    w_advance = 1'b1;
                end
                // Leaving the last lane without reaching N: a final word means a short stream.
                if (w_advance && (r_lane == 2'd3)) begin
                    w_state_nxt = r_buf_last ? S_DONE : S_LOAD;
                    w_set_error = r_buf_last;
                end
            end
            S_DRAIN: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_data <= '0;
            r_buf_keep <= '0;
            r_buf_last <= 1'b0;
            r_lane     <= '0;
            r_cnt      <= '0;
            r_error    <= 1'b0;
        end else begin
            if (w_run_start) begin
                r_cnt   <= '0;
                r_error <= 1'b0;
            end
            if (w_load) begin
                r_buf_data <= in_data;
                r_buf_keep <= in_keep;
                r_buf_last <= in_last;
                r_lane     <= '0;
            end
            if (w_take) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_advance) begin
                r_lane <= r_lane + 2'd1;
            end
            if (w_set_error) begin
                r_error <= 1'b1;
            end
        end
    end

    assign coeff     = coeff_valid ? w_cand[COEFF_W-1:0] : '0;
    assign coeff_cnt = r_cnt;
    assign error     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_shake_coeff_sampler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_shake_coeff_sampler
// Brief    : Scoreboard bench: queued reference coefficients vs. DUT stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shake_coeff_sampler;

    localparam int Q       = 12289;
    localparam int COEFF_W = 14;
    localparam int N       = 6;
    localparam int CNT_W   = $clog2(N + 1);

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [63:0]        in_data = '0;
    logic [7:0]         in_keep = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               in_last = 1'b0;
    logic [COEFF_W-1:0] coeff;
    logic               coeff_valid;
    logic               coeff_ready = 1'b0;
    logic               coeff_last;
    logic [CNT_W-1:0]   coeff_cnt;
    logic               done;
    logic               error;

    shake_coeff_sampler #(.Q(Q), .COEFF_W(COEFF_W), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_data(in_data), .in_keep(in_keep), .in_valid(in_valid),
        .in_ready(in_ready), .in_last(in_last),
        .coeff(coeff), .coeff_valid(coeff_valid), .coeff_ready(coeff_ready),
        .coeff_last(coeff_last), .coeff_cnt(coeff_cnt),
        .done(done), .error(error)
    );

    typedef struct { logic [COEFF_W-1:0] c; logic last; } exp_t;
    typedef struct { logic err; int cnt; } run_t;

    exp_t        exp_q[$];
    run_t        run_q[$];
    logic [63:0] w_data[$];
    logic [7:0]  w_keep[$];

    int checks = 0, errors = 0, cycle = 0, runs_done = 0;
    int ready_mode = 0;                // 0 random, 1 toggle, 2 always, 3 never
    bit no_gaps = 0, hold_pending = 0, done_prev = 0, summary_done = 0;
    logic [COEFF_W-1:0] held;
    int t_first = 0, t_done = 0;

    initial forever #5 clk = ~clk;
    always @(posedge clk) cycle++;

    initial forever begin
        @(posedge clk); #1;
        case (ready_mode)
            0:       coeff_ready = ($urandom_range(9) < 7);
            1:       coeff_ready = ~coeff_ready;
            2:       coeff_ready = 1'b1;
            default: coeff_ready = 1'b0;
        endcase
    end

    task automatic summary();
        if (!summary_done) begin
            summary_done = 1;
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        end
    endtask

    task automatic timeout(input string what);
        checks++; errors++;
        $display("FAIL %s: wait bound expired at cycle %0d, required event not seen", what, cycle);
        summary();
        $finish;
    endtask

    // Reference: every lane in order, keep both bytes, mask, accept < Q, stop at N.
    task automatic model_run();
        int acc, v;
        acc = 0;
        for (int w = 0; w < w_data.size(); w++) begin
            for (int i = 0; i < 4; i++) begin
                v = int'(w_data[w][16*i +: 16]) % (1 << COEFF_W);
                if (w_keep[w][2*i] && w_keep[w][2*i+1] && v < Q && acc < N) begin
                    acc++;
                    exp_q.push_back('{c: COEFF_W'(v), last: (acc == N)});
                end
            end
        end
        run_q.push_back('{err: (acc < N), cnt: acc});
    endtask

    function automatic logic [15:0] rand_lane();
        logic [15:0] hi;
        hi = 16'($urandom_range(3)) << COEFF_W;
        case ($urandom_range(4))
            0:       return hi | 16'(Q - 1);
            1:       return hi | 16'(Q);
            2:       return 16'($urandom_range(3));
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic build_random();
        int nw;
        logic [63:0] d;
        nw = $urandom_range(4, 1);
        w_data.delete(); w_keep.delete();
        for (int w = 0; w < nw; w++) begin
            for (int i = 0; i < 4; i++) d[16*i +: 16] = rand_lane();
            w_data.push_back(d);
            w_keep.push_back(($urandom_range(3) == 0) ? 8'($urandom) : 8'hFF);
        end
    endtask

    task automatic do_run();
        int t, target;
        target = runs_done + 1;
        model_run();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int w = 0; w < w_data.size(); w++) begin
            in_data = w_data[w];
            in_keep = w_keep[w];
            in_last = (w == w_data.size() - 1);
            if (!no_gaps) begin
                while ($urandom_range(3) == 0) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            t = 0;
            @(negedge clk);
            while (!in_ready) begin
                t++;
                if (t > 200) timeout("in_handshake");
                @(posedge clk); #1;
                start = (!no_gaps && $urandom_range(7) == 0);   // must be ignored mid-run
                @(negedge clk);
            end
            if (w == 0) t_first = cycle;
            @(posedge clk); #1 start = 1'b0;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        t = 0;
        while (runs_done < target) begin
            @(posedge clk);
            t++;
            if (t > 500) timeout("done_pulse");
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_pending) begin
                checks++;
                if (!coeff_valid || coeff !== held) begin
                    errors++;
                    $display("FAIL coeff_stable: got valid=%0b coeff=%0d, required valid=1 coeff=%0d",
                             coeff_valid, coeff, held);
                end
                hold_pending = 0;
            end
            if (coeff_valid && coeff_ready) begin
                exp_t e;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL coeff_extra: got coeff=%0d, required no output", coeff);
                end else begin
                    e = exp_q.pop_front();
                    if (coeff !== e.c || coeff_last !== e.last) begin
                        errors++;
                        $display("FAIL coeff: got %0d last=%0b, required %0d last=%0b",
                                 coeff, coeff_last, e.c, e.last);
                    end
                end
            end else if (coeff_valid) begin
                hold_pending = 1;
                held = coeff;
            end
            if (done) begin
                run_t r;
                checks++;
                t_done = cycle;
                if (done_prev) begin
                    errors++;
                    $display("FAIL done_width: got done high 2 cycles, required 1");
                end else if (run_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_extra: got done, required none");
                end else begin
                    r = run_q.pop_front();
                    if (error !== r.err || int'(coeff_cnt) != r.cnt || exp_q.size() != 0) begin
                        errors++;
                        $display("FAIL run_end: got error=%0b cnt=%0d pending=%0d, required error=%0b cnt=%0d pending=0",
                                 error, coeff_cnt, exp_q.size(), r.err, r.cnt);
                    end
                end
                runs_done++;
            end
            done_prev = done;
        end
    end

    initial begin
        #2000000;
        timeout("watchdog");
    end

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, coeff, coeff_valid, coeff_last, coeff_cnt, done, error} !== '0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%0b coeff=%0d v=%0b last=%0b cnt=%0d done=%0b err=%0b, required all 0",
                     in_ready, coeff, coeff_valid, coeff_last, coeff_cnt, done, error);
        end
        rst_n = 1'b1;

        // Short stream: 5, 12288, 1 then error
        w_data = '{64'h0001_3001_3000_0005}; w_keep = '{8'hFF};
        do_run();
        // Partial lane skipped
        w_data = '{64'h0000_0000_0002_0001}; w_keep = '{8'h07};
        do_run();
        // N-th coefficient in the final word
        w_data = '{64'h0001_3001_3000_0005, 64'h0003_0002_0001_0000}; w_keep = '{8'hFF, 8'hFF};
        do_run();
        // N reached early: remaining words drained
        w_data = '{64'h0003_0002_0001_0000, 64'h0003_0002_0001_0000,
                   64'h0003_0002_0001_0000, 64'h0003_0002_0001_0000};
        w_keep = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        do_run();

        // Latency: 5 cycles for the full word, 3 more, then done
        ready_mode = 2; no_gaps = 1;
        w_data = '{64'h0003_0002_0001_0000, 64'h0003_0002_0001_0000}; w_keep = '{8'hFF, 8'hFF};
        do_run();
        checks++;
        if (t_done - t_first != 8) begin
            errors++;
            $display("FAIL latency: got %0d cycles, required 8", t_done - t_first);
        end
        no_gaps = 0;

        ready_mode = 1;
        repeat (10) begin build_random(); do_run(); end
        ready_mode = 0;
        repeat (40) begin build_random(); do_run(); end

        // Reset mid-SCAN
        ready_mode = 3; no_gaps = 1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        in_data = 64'h0003_0002_0001_0000; in_keep = 8'hFF; in_last = 1'b0; in_valid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; if (t > 50) timeout("reset_load"); end while (!in_ready);
        @(posedge clk); #1 in_valid = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; if (t > 50) timeout("reset_scan"); end while (!coeff_valid);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, coeff, coeff_valid, coeff_last, coeff_cnt, done, error} !== '0) begin
            errors++;
            $display("FAIL async_reset: got rdy=%0b coeff=%0d v=%0b cnt=%0d done=%0b err=%0b, required all 0",
                     in_ready, coeff, coeff_valid, coeff_cnt, done, error);
        end
        hold_pending = 0; done_prev = 0;
        exp_q.delete(); run_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        ready_mode = 0; no_gaps = 0;
        w_data = '{64'h0001_3001_3000_0005, 64'h0003_0002_0001_0000}; w_keep = '{8'hFF, 8'hFF};
        do_run();
        repeat (5) begin build_random(); do_run(); end

        repeat (3) @(posedge clk);
        summary();
        $finish;
    end

endmodule
`default_nettype wire
